// File: rtl/cache_traffic_gen_if.sv
// rtl/cache_traffic_gen_if.sv - cache access bus between traffic generator and cache
// Ports (signals):
//   cache_read   request: read access
//   cache_write  request: write access
//   address      access address (ADDR_W)
//   cache_ready  cache completes the presented access this cycle
//   cache_hit    hit status of the completing access
// Modports: master (generator side), slave (cache side).
interface cache_traffic_gen_if #(
  parameter int ADDR_W = 15
);
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] address;
  logic              cache_ready;
  logic              cache_hit;

  modport master (
    output cache_read,
    output cache_write,
    output address,
    input  cache_ready,
    input  cache_hit
  );

  modport slave (
    input  cache_read,
    input  cache_write,
    input  address,
    output cache_ready,
    output cache_hit
  );
endinterface

// File: rtl/cache_traffic_gen.sv
// rtl/cache_traffic_gen.sv - strided cache traffic generator with hit-rate divider
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a run (honoured in IDLE/DONE only)
//   bus            cache access bus, master side
//   busy           high while issuing accesses or dividing
//   done           run finished, results valid
//   hit_total      hits counted in the current/last run
//   hit_rate_pct   floor(hit_total*100/NUM_ACCESSES)
module cache_traffic_gen #(
  parameter int ADDR_W       = 15,
  parameter int CNT_W        = 14,
  parameter int START_ADDR   = 1024,
  parameter int NUM_ACCESSES = 8192,
  parameter int STRIDE       = 1,
  parameter int WRITE_EVERY  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  cache_traffic_gen_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    hit_total,
  output logic [6:0]          hit_rate_pct
);

  localparam int DIV_W = CNT_W + 7;
  localparam int DC_W  = $clog2(DIV_W + 1);
  localparam int WP_W  = (WRITE_EVERY > 1) ? $clog2(WRITE_EVERY) : 1;

  localparam logic [WP_W-1:0]   WP_LAST   = WP_W'((WRITE_EVERY > 0) ? WRITE_EVERY - 1 : 0);
  localparam logic              WR_FIRST  = (WRITE_EVERY == 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_ACCESSES - 1);
  localparam logic [CNT_W:0]    DIVISOR   = (CNT_W + 1)'(NUM_ACCESSES);
  localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRIDE);
  localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(DIV_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t            state, state_next;
  logic              req_rd, req_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [WP_W-1:0]   wr_phase;
  // dvd shifts the dividend out at the top while quotient bits enter at the bottom
  logic [DIV_W-1:0]  dvd;
  logic [CNT_W-1:0]  rem;
  logic [DC_W-1:0]   div_cnt;

  logic              hs, last, div_last, wr_next, ge;
  logic [CNT_W-1:0]  hit_next;
  logic [WP_W-1:0]   phase_next;
  logic [CNT_W:0]    trial;
  logic [CNT_W-1:0]  rem_next;
  logic [DIV_W-1:0]  quo;

  assign bus.cache_read  = req_rd;
  assign bus.cache_write = req_wr;
  assign bus.address     = addr_q;

  always_comb begin
    state_next = state;
    hs         = (state == RUN) && (req_rd || req_wr) && bus.cache_ready;
    last       = hs && (acc_cnt == CNT_LAST);
    div_last   = (state == DIV) && (div_cnt == DC_LAST);
    hit_next   = hit_total + CNT_W'(bus.cache_hit);
    // wrap counter gives the access index modulo WRITE_EVERY without a divider
    phase_next = ((WRITE_EVERY > 0) && (wr_phase == WP_LAST)) ? '0 : wr_phase + WP_W'(1);
    wr_next    = (WRITE_EVERY > 0) && (phase_next == WP_LAST);
    trial      = {rem, dvd[DIV_W-1]};
    ge         = (trial >= DIVISOR);
    rem_next   = ge ? CNT_W'(trial - DIVISOR) : trial[CNT_W-1:0];
    quo        = {dvd[DIV_W-2:0], ge};

    case (state)
      IDLE, DONE: if (start)    state_next = RUN;
      RUN:        if (last)     state_next = DIV;
      DIV:        if (div_last) state_next = DONE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rd       <= 1'b0;
      req_wr       <= 1'b0;
      addr_q       <= ADDR_INIT;
      acc_cnt      <= '0;
      wr_phase     <= '0;
      hit_total    <= '0;
      hit_rate_pct <= '0;
      dvd          <= '0;
      rem          <= '0;
      div_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy <= (state_next == RUN) || (state_next == DIV);
      done <= (state_next == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hit_total <= '0;
            acc_cnt   <= '0;
            wr_phase  <= '0;
            addr_q    <= ADDR_INIT;
            req_rd    <= !WR_FIRST;
            req_wr    <= WR_FIRST;
          end
        end
        RUN: begin
          if (hs) begin
            hit_total <= hit_next;
            acc_cnt   <= acc_cnt + CNT_W'(1);
            addr_q    <= addr_q + ADDR_STEP;
            wr_phase  <= phase_next;
            if (last) begin
              req_rd  <= 1'b0;
              req_wr  <= 1'b0;
              // final hit is folded in here so the divider starts on the next edge
              dvd     <= DIV_W'(hit_next) * DIV_W'(100);
              rem     <= '0;
              div_cnt <= '0;
            end else begin
              req_rd  <= !wr_next;
              req_wr  <= wr_next;
            end
          end
        end
        DIV: begin
          rem     <= rem_next;
          dvd     <= quo;
          div_cnt <= div_cnt + DC_W'(1);
          if (div_last) hit_rate_pct <= quo[6:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// tb/tb_cache_traffic_gen.sv - scoreboard bench for cache_traffic_gen
module tb_cache_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [13:0] hit_total_a, hit_total_b;
  logic [6:0]  pct_a, pct_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int addr; int wr;} acc_t;
  typedef struct {int hits; int pct; int lat;} res_t;

  acc_t qa[$], qb[$];
  res_t ra[$], rb[$];
  int   start_cyc_a, start_cyc_b;
  logic done_a_q = 1'b0, done_b_q = 1'b0;
  int   hm_a = 0, hm_b = 0;
  bit   bp_b = 1'b0;

  int b_addr[8] = '{32766, 32767, 0, 1, 2, 3, 4, 5};
  int b_wr[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};

  cache_traffic_gen_if #(.ADDR_W(15)) bus_a();
  cache_traffic_gen_if #(.ADDR_W(15)) bus_b();

  cache_traffic_gen #(.NUM_ACCESSES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .hit_total(hit_total_a), .hit_rate_pct(pct_a)
  );

  cache_traffic_gen #(.START_ADDR(32766), .NUM_ACCESSES(8), .WRITE_EVERY(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .hit_total(hit_total_b), .hit_rate_pct(pct_b)
  );

  // cache responders: hit pattern keyed on the presented address
  always_comb bus_a.cache_hit = (hm_a == 1) ? 1'b1 : ~bus_a.address[0];
  always_comb bus_b.cache_hit = (hm_b == 1) ? (bus_b.address < 15'd3) : ~bus_b.address[0];

  always @(posedge clk) begin
    #2;
    bus_b.cache_ready = bp_b ? (cyc % 3 == 0) : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.cache_read || bus_a.cache_write) begin
        chk("a_onehot", int'(bus_a.cache_read) + int'(bus_a.cache_write), 1);
        if (qa.size() == 0) chk("a_unexpected_req", 1, 0);
        else begin
          chk("a_addr", int'(bus_a.address), qa[0].addr);
          chk("a_wr", int'(bus_a.cache_write), qa[0].wr);
          if (bus_a.cache_ready) void'(qa.pop_front());
        end
      end
      if (done_a && !done_a_q) begin
        if (ra.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          res_t r;
          r = ra.pop_front();
          chk("a_hit_total", int'(hit_total_a), r.hits);
          chk("a_pct", int'(pct_a), r.pct);
          if (r.lat >= 0) chk("a_latency", cyc - start_cyc_a, r.lat);
        end
      end
      done_a_q = done_a;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.cache_read || bus_b.cache_write) begin
        chk("b_onehot", int'(bus_b.cache_read) + int'(bus_b.cache_write), 1);
        if (qb.size() == 0) chk("b_unexpected_req", 1, 0);
        else begin
          chk("b_addr", int'(bus_b.address), qb[0].addr);
          chk("b_wr", int'(bus_b.cache_write), qb[0].wr);
          if (bus_b.cache_ready) void'(qb.pop_front());
        end
      end
      if (done_b && !done_b_q) begin
        if (rb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          res_t r;
          r = rb.pop_front();
          chk("b_hit_total", int'(hit_total_b), r.hits);
          chk("b_pct", int'(pct_b), r.pct);
          if (r.lat >= 0) chk("b_latency", cyc - start_cyc_b, r.lat);
        end
      end
      done_b_q = done_b;
    end
  end

  task automatic pulse_start(input bit is_b);
    @(posedge clk); #2;
    if (is_b) begin start_b = 1'b1; start_cyc_b = cyc + 1; end
    else      begin start_a = 1'b1; start_cyc_a = cyc + 1; end
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit is_b);
    bit seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if ((is_b ? done_b : done_a) == 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) chk(is_b ? "b_done_timeout" : "a_done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) qa.push_back('{1024 + i, 0});
  endtask

  task automatic push_b();
    for (int i = 0; i < 8; i++) qb.push_back('{b_addr[i], b_wr[i]});
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_addr"}, int'(bus_a.address), 1024);
    chk({tag, "_rd"}, int'(bus_a.cache_read), 0);
    chk({tag, "_wr"}, int'(bus_a.cache_write), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_hits"}, int'(hit_total_a), 0);
    chk({tag, "_pct"}, int'(pct_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.cache_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");
    chk("rst_b_addr", int'(bus_b.address), 32766);
    #1 rst_n = 1'b1;

    // idle: no requests without start
    repeat (20) @(posedge clk);
    #1;
    chk("idle_req", int'(bus_a.cache_read) + int'(bus_a.cache_write), 0);
    chk("idle_busy", int'(busy_a), 0);

    // full run, alternating hits
    push_a();
    ra.push_back('{8, 50, 37});
    pulse_start(1'b0);
    wait_done(1'b0);
    chk("a_run1_left", qa.size(), 0);

    // reset during access 5
    push_a();
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_hits", int'(hit_total_a), 3);
    chk("mid_addr", int'(bus_a.address), 1029);
    chk("mid_busy", int'(busy_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_a("midrst");
    qa.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // clean run after reset
    push_a();
    ra.push_back('{8, 50, 37});
    pulse_start(1'b0);
    wait_done(1'b0);

    // restart from DONE with all hits; old percentage held while running
    hm_a = 1;
    push_a();
    ra.push_back('{16, 100, 37});
    pulse_start(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pct", int'(pct_a), 50);
    chk("hold_done", int'(done_a), 0);
    chk("hold_busy", int'(busy_a), 1);
    wait_done(1'b0);
    chk("a_run4_left", qa.size(), 0);

    // write mix with address wrap
    push_b();
    rb.push_back('{4, 50, 29});
    pulse_start(1'b1);
    wait_done(1'b1);
    chk("b_run1_left", qb.size(), 0);

    // same sequence under backpressure
    bp_b = 1'b1;
    hm_b = 1;
    push_b();
    rb.push_back('{3, 37, -1});
    pulse_start(1'b1);
    wait_done(1'b1);
    chk("b_run2_left", qb.size(), 0);

    chk("a_results_left", ra.size(), 0);
    chk("b_results_left", rb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
